// File: rtl/lsu_cache_req_pkg.sv
// Shared types, funct3 codes and cache control encodings for the LSU request sequencer.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [4:0] LD_NONE = 5'b00000;
  localparam logic [4:0] LD_LB   = 5'b00001;
  localparam logic [4:0] LD_LH   = 5'b00010;
  localparam logic [4:0] LD_LW   = 5'b00100;
  localparam logic [4:0] LD_LBU  = 5'b01000;
  localparam logic [4:0] LD_LHU  = 5'b10000;

  localparam logic [2:0] ST_NONE = 3'b000;
  localparam logic [2:0] ST_SB   = 3'b001;
  localparam logic [2:0] ST_SH   = 3'b010;
  localparam logic [2:0] ST_SW   = 3'b100;

  function automatic logic [4:0] load_cntrl(input logic [2:0] f3);
    logic [4:0] lc;
    case (f3)
      F3_B:    lc = LD_LB;
      F3_H:    lc = LD_LH;
      F3_W:    lc = LD_LW;
      F3_BU:   lc = LD_LBU;
      F3_HU:   lc = LD_LHU;
      default: lc = LD_NONE;
    endcase
    return lc;
  endfunction

  function automatic logic [2:0] store_cntrl(input logic [2:0] f3);
    logic [2:0] sc;
    case (f3)
      F3_B:    sc = ST_SB;
      F3_H:    sc = ST_SH;
      F3_W:    sc = ST_SW;
      default: sc = ST_NONE;
    endcase
    return sc;
  endfunction

  // An op that maps to no control code is illegal; width comes from funct3[1:0].
  function automatic logic req_error(input req_t r);
    logic illegal;
    logic misaligned;
    illegal = r.we ? (store_cntrl(r.funct3) == ST_NONE) : (load_cntrl(r.funct3) == LD_NONE);
    case (r.funct3[1:0])
      2'b01:   misaligned = r.addr[0];
      2'b10:   misaligned = (r.addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    return illegal | misaligned;
  endfunction

endpackage

// File: rtl/lsu_cache_req_if.sv
// Pipeline request/response and data-cache bus of the LSU request sequencer.
interface lsu_cache_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ren;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] din;
  logic [4:0]  loadcntrl;
  logic [2:0]  storecntrl;
  logic        cache_rdy;
  logic [31:0] dout;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, cache_rdy, dout,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output ren, wen, addr, din, loadcntrl, storecntrl
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, cache_rdy, dout,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  ren, wen, addr, din, loadcntrl, storecntrl
  );
endinterface

// File: rtl/lsu_cache_req_fifo.sv
// lsu_req_fifo: QDEPTH-entry request FIFO with registered count; head is the oldest entry.
module lsu_req_fifo
  import lsu_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  req_t                      push_data_i,
  input  logic                      pop_i,
  output req_t                      head_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(QDEPTH):0]   count_o
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  req_t          mem_q [QDEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_s;
  logic          pop_s;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/lsu_cache_req.sv
// lsu_cache_req: in-order load/store sequencer in front of the data cache.
// Optional watchdog enabled with LSU_TIMEOUT_EN.
module lsu_cache_req
  import lsu_pkg::*;
#(
  parameter int QDEPTH = 2
`ifdef LSU_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic          clk,
  input  logic          rst,
  lsu_cache_req_if.slave bus
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] ONE_C = CW'(1);

  req_t          push_req_s;
  req_t          head_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic [CW-1:0] count_s;
  logic          head_err_s;
  logic          timeout_s;

  state_t        state_q, state_d;
  logic          head_vld_q, head_vld_d;
  logic          ren_q, ren_d;
  logic          wen_q, wen_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   din_q, din_d;
  logic [4:0]    loadcntrl_q, loadcntrl_d;
  logic [2:0]    storecntrl_q, storecntrl_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;

  assign push_req_s = '{we: bus.req_we, funct3: bus.req_funct3,
                        addr: bus.req_addr, wdata: bus.req_wdata};
  assign push_s     = bus.req_valid & ~full_s;
  assign head_err_s = req_error(head_s);

  lsu_req_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .push_data_i (push_req_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .full_o      (full_s),
    .empty_o     (empty_s),
    .count_o     (count_s)
  );

  // The head is acted on only once it has sat in the FIFO for a cycle, which
  // gives the decode a full cycle; an entry leaving this edge does not count.
  assign head_vld_d = ~empty_s & ~(pop_s & (count_s == ONE_C));

`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] TO_LAST_C = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_q;

  // Watchdog: cycles spent in ISSUE+BUSY for the current op
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= 16'd0;
    end else if (state_q == IDLE && state_d == ISSUE) begin
      wd_q <= 16'd0;
    end else if (state_q == ISSUE || state_q == BUSY) begin
      wd_q <= wd_q + 16'd1;
    end else begin
      wd_q <= wd_q;
    end
  end

  assign timeout_s = ((state_q == ISSUE) || (state_q == BUSY)) && (wd_q == TO_LAST_C);
`else
  assign timeout_s = 1'b0;
`endif

  // Next state and next values of the registered outputs
  always_comb begin
    state_d      = state_q;
    ren_d        = ren_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    din_d        = din_q;
    loadcntrl_d  = loadcntrl_q;
    storecntrl_d = storecntrl_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0000_0000;
    pop_s        = 1'b0;

    case (state_q)
      IDLE: begin
        if (head_vld_q && !empty_s) begin
          if (head_err_s) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (bus.cache_rdy) begin
            state_d      = ISSUE;
            ren_d        = ~head_s.we;
            wen_d        = head_s.we;
            addr_d       = head_s.addr;
            din_d        = head_s.we ? head_s.wdata : 32'h0000_0000;
            loadcntrl_d  = head_s.we ? LD_NONE : load_cntrl(head_s.funct3);
            storecntrl_d = head_s.we ? store_cntrl(head_s.funct3) : ST_NONE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end

      ISSUE: begin
        if (timeout_s || !bus.cache_rdy) begin
          // Cache has taken the op (or is unresponsive): strobes and controls drop, addr/din hold
          state_d      = timeout_s ? RESP : BUSY;
          ren_d        = 1'b0;
          wen_d        = 1'b0;
          loadcntrl_d  = LD_NONE;
          storecntrl_d = ST_NONE;
          resp_valid_d = timeout_s;
          resp_err_d   = timeout_s;
        end else begin
          state_d = ISSUE;
        end
      end

      BUSY: begin
        if (timeout_s) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else if (bus.cache_rdy) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = head_s.we ? 32'h0000_0000 : bus.dout;
        end else begin
          state_d = BUSY;
        end
      end

      RESP: begin
        pop_s   = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d      = IDLE;
        ren_d        = 1'b0;
        wen_d        = 1'b0;
        loadcntrl_d  = LD_NONE;
        storecntrl_d = ST_NONE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      head_vld_q   <= 1'b0;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= 32'h0000_0000;
      din_q        <= 32'h0000_0000;
      loadcntrl_q  <= LD_NONE;
      storecntrl_q <= ST_NONE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      head_vld_q   <= head_vld_d;
      ren_q        <= ren_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      loadcntrl_q  <= loadcntrl_d;
      storecntrl_q <= storecntrl_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = ~full_s;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.ren        = ren_q;
  assign bus.wen        = wen_q;
  assign bus.addr       = addr_q;
  assign bus.din        = din_q;
  assign bus.loadcntrl  = loadcntrl_q;
  assign bus.storecntrl = storecntrl_q;

endmodule

// File: tb/tb_lsu_cache_req.sv
// Directed, table-driven bench for lsu_cache_req with a small reactive cache model.
module tb_lsu_cache_req;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_cache_req_if bus ();

  lsu_cache_req #(
    .QDEPTH(2)
`ifdef LSU_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dout;
    logic        op;
    logic [4:0]  lc;
    logic [2:0]  sc;
    logic [31:0] din;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vec [15];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] dout, input logic op,
                              input logic [4:0] lc, input logic [2:0] sc, input logic [31:0] din,
                              input logic [31:0] rdata, input logic err);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.dout = dout; v.op = op;
    v.lc = lc; v.sc = sc; v.din = din; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input int i);
    bus.req_valid  = 1'b1;
    bus.req_we     = vec[i].we;
    bus.req_funct3 = vec[i].f3;
    bus.req_addr   = vec[i].addr;
    bus.req_wdata  = vec[i].wdata;
  endtask

  // Push vec[first..first+n-1] as fast as accepted, play the cache, check every op and response
  task automatic run(input int first, input int n);
    int sent, got, phase, cnt, both, idx, a;
    bit op_seen, saw_full;
    int pend[$];
    int acc[$];
    sent = 0; got = 0; phase = 0; cnt = 0; both = 0;
    op_seen = 1'b0; saw_full = 1'b0;
    bus.cache_rdy = 1'b1;
    for (int t = 0; t < 400 && got < n; t++) begin
      @(negedge clk);
      if (bus.ren && bus.wen) both++;
      if (bus.resp_valid) begin
        if (pend.size() == 0) begin
          chk("spurious_resp", 32'd1, 32'd0);
        end else begin
          idx = pend.pop_front();
          a   = acc.pop_front();
          chk("resp_rdata", bus.resp_rdata, vec[idx].rdata);
          chk("resp_err", {31'd0, bus.resp_err}, {31'd0, vec[idx].err});
          if (n == 1 && vec[idx].err) chk("err_latency", cyc - a, 32'd2);
        end
        got++;
        op_seen = 1'b0;
        phase = 0;
        bus.cache_rdy = 1'b1;
      end
      if ((bus.ren || bus.wen) && !op_seen) begin
        op_seen = 1'b1;
        if (pend.size() == 0) begin
          chk("spurious_op", 32'd1, 32'd0);
        end else begin
          idx = pend[0];
          chk("ren", {31'd0, bus.ren}, {31'd0, vec[idx].op & ~vec[idx].we});
          chk("wen", {31'd0, bus.wen}, {31'd0, vec[idx].op & vec[idx].we});
          chk("loadcntrl", {27'd0, bus.loadcntrl}, {27'd0, vec[idx].lc});
          chk("storecntrl", {29'd0, bus.storecntrl}, {29'd0, vec[idx].sc});
          chk("addr", bus.addr, vec[idx].addr);
          chk("din", bus.din, vec[idx].din);
          if (n == 1) chk("issue_latency", cyc - acc[0], 32'd2);
        end
      end
      // Cache: drop rdy one cycle after the strobe, return data 3 cycles later
      if (phase == 0 && (bus.ren || bus.wen)) begin
        bus.cache_rdy = 1'b0;
        phase = 1;
        cnt = 0;
      end else if (phase == 1) begin
        cnt++;
        if (cnt == 3) begin
          bus.cache_rdy = 1'b1;
          bus.dout = (pend.size() != 0) ? vec[pend[0]].dout : 32'h0;
          phase = 2;
        end
      end
      if (sent < n) begin
        drive_req(first + sent);
        if (bus.req_ready) begin
          pend.push_back(first + sent);
          acc.push_back(cyc + 1);
          sent++;
        end else if (sent == 2) begin
          saw_full = 1'b1;
        end
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    chk("resp_count", got, n);
    chk("ren_wen_exclusive", both, 32'd0);
    if (n == 3) chk("full_backpressure", {31'd0, saw_full}, 32'd1);
  endtask

  int quiet;
  int c0;
  bit seen;

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.cache_rdy = 1'b1; bus.dout = 32'h0;

    //           we    f3      addr          wdata         dout          op    lc        sc      din           rdata         err
    vec[0]  = mk(1'b0, 3'b010, 32'h00000004, 32'h0,        32'hDEADBEEF, 1'b1, 5'b00100, 3'b000, 32'h0,        32'hDEADBEEF, 1'b0);
    vec[1]  = mk(1'b1, 3'b010, 32'hACE12000, 32'h12345678, 32'hCAFEF00D, 1'b1, 5'b00000, 3'b100, 32'h12345678, 32'h0,        1'b0);
    vec[2]  = mk(1'b0, 3'b001, 32'h00000003, 32'h0,        32'h0,        1'b0, 5'b00000, 3'b000, 32'h0,        32'h0,        1'b1);
    vec[3]  = mk(1'b1, 3'b010, 32'h00000002, 32'h55555555, 32'h0,        1'b0, 5'b00000, 3'b000, 32'h0,        32'h0,        1'b1);
    vec[4]  = mk(1'b0, 3'b010, 32'h00000000, 32'h0,        32'h11111111, 1'b1, 5'b00100, 3'b000, 32'h0,        32'h11111111, 1'b0);
    vec[5]  = mk(1'b0, 3'b010, 32'h00000004, 32'h0,        32'h22222222, 1'b1, 5'b00100, 3'b000, 32'h0,        32'h22222222, 1'b0);
    vec[6]  = mk(1'b0, 3'b010, 32'h00000008, 32'h0,        32'h33333333, 1'b1, 5'b00100, 3'b000, 32'h0,        32'h33333333, 1'b0);
    vec[7]  = mk(1'b0, 3'b100, 32'h00000005, 32'h0,        32'h000000AB, 1'b1, 5'b01000, 3'b000, 32'h0,        32'h000000AB, 1'b0);
    vec[8]  = mk(1'b1, 3'b000, 32'h00000007, 32'h000000FF, 32'hCAFEF00D, 1'b1, 5'b00000, 3'b001, 32'h000000FF, 32'h0,        1'b0);
    vec[9]  = mk(1'b0, 3'b011, 32'h00000000, 32'h0,        32'h0,        1'b0, 5'b00000, 3'b000, 32'h0,        32'h0,        1'b1);
    vec[10] = mk(1'b1, 3'b100, 32'h00000000, 32'h0000BEEF, 32'h0,        1'b0, 5'b00000, 3'b000, 32'h0,        32'h0,        1'b1);
    vec[11] = mk(1'b0, 3'b101, 32'h00000002, 32'h0,        32'h0000BEEF, 1'b1, 5'b10000, 3'b000, 32'h0,        32'h0000BEEF, 1'b0);
    vec[12] = mk(1'b1, 3'b001, 32'h00000006, 32'h0000A5A5, 32'hCAFEF00D, 1'b1, 5'b00000, 3'b010, 32'h0000A5A5, 32'h0,        1'b0);
    vec[13] = mk(1'b0, 3'b000, 32'h00000001, 32'h0,        32'hFFFFFF80, 1'b1, 5'b00001, 3'b000, 32'h0,        32'hFFFFFF80, 1'b0);
    vec[14] = mk(1'b0, 3'b010, 32'h00000002, 32'h0,        32'h0,        1'b0, 5'b00000, 3'b000, 32'h0,        32'h0,        1'b1);

    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_ren_wen", {30'd0, bus.ren, bus.wen}, 32'd0);
    chk("rst_addr", bus.addr, 32'h0);
    chk("rst_din", bus.din, 32'h0);
    chk("rst_cntrl", {24'd0, bus.loadcntrl, bus.storecntrl}, 32'd0);
    chk("rst_resp", {bus.resp_rdata[30:0], bus.resp_err}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) run(i, 1);
    run(4, 3);
    run(7, 8);

    // Reset while BUSY with a second request still queued
    bus.cache_rdy = 1'b1;
    @(negedge clk); drive_req(4); bus.req_addr = 32'h00000040;
    @(negedge clk); drive_req(5); bus.req_addr = 32'h00000044;
    @(negedge clk); bus.req_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      if (bus.ren) seen = 1'b1;
      else @(negedge clk);
    end
    chk("rst_test_issue", {31'd0, seen}, 32'd1);
    bus.cache_rdy = 1'b0;
    @(negedge clk);
    chk("busy_addr_hold", bus.addr, 32'h00000040);
    #2 rst = 1'b0;
    #1;
    chk("midrst_ren_wen", {30'd0, bus.ren, bus.wen}, 32'd0);
    chk("midrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("midrst_addr", bus.addr, 32'h0);
    chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    bus.cache_rdy = 1'b1;
    quiet = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.ren || bus.wen || bus.resp_valid) quiet++;
    end
    chk("no_stale_activity", quiet, 32'd0);
    chk("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    run(1, 1);

`ifdef LSU_TIMEOUT_EN
    // Cache never comes back after taking the op
    @(negedge clk); drive_req(0);
    @(negedge clk); bus.req_valid = 1'b0;
    seen = 1'b0; c0 = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      if (bus.ren) begin seen = 1'b1; c0 = cyc; end
      else @(negedge clk);
    end
    chk("to_issue", {31'd0, seen}, 32'd1);
    bus.cache_rdy = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
    end
    chk("to_resp", {31'd0, seen}, 32'd1);
    chk("to_latency", cyc - c0, 32'd16);
    chk("to_err", {31'd0, bus.resp_err}, 32'd1);
    chk("to_rdata", bus.resp_rdata, 32'h0);
    bus.cache_rdy = 1'b1;
    run(0, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
